// File: rtl/ntt_butterfly_pipe.sv
// NTT butterfly (CT forward / GS inverse) around one combinational modular multiplier.
// Latency: 3 register stages; a pair accepted at edge N is valid after edge N+2 and is consumed at edge N+3 at the earliest.
// Backpressure: one global advance (!out_valid || out_ready) freezes every stage; in_ready is that advance, so bubbles are held.

module mod_mult #(
    parameter int WIDTH          = 32,
    parameter int Q              = 3329,
    parameter int REDUCTION_TYPE = 0
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] p
);
    localparam int PW = 2 * WIDTH;
    localparam logic [PW-1:0] QP = PW'(Q);

    // -Q^-1 mod 2^WIDTH by Newton iteration; each step doubles the correct low bits.
    function automatic logic [WIDTH-1:0] neg_qinv();
        logic [WIDTH-1:0] inv;
        inv = WIDTH'(1);
        for (int i = 0; i < 7; i++) begin
            inv = inv * (WIDTH'(2) - WIDTH'(Q) * inv);
        end
        return -inv;
    endfunction

    logic [PW-1:0] prod;
    assign prod = PW'(x) * PW'(y);

    generate
        if (REDUCTION_TYPE == 1) begin : g_barrett
            localparam int K = 2 * $clog2(Q);
            localparam logic [K:0] MU = ((K+1)'(1) << K) / (K+1)'(Q);
            logic [PW+K:0] qm;
            logic [PW-1:0] q_est;
            logic [PW-1:0] r0;
            logic [PW-1:0] r1;
            // Quotient estimate is at most two short, hence two conditional subtractions.
            always_comb begin
                qm    = (PW+K+1)'(prod) * (PW+K+1)'(MU);
                q_est = PW'(qm >> K);
                r0    = prod - q_est * QP;
                r1    = (r0 >= QP) ? (r0 - QP) : r0;
                p     = (r1 >= QP) ? WIDTH'(r1 - QP) : WIDTH'(r1);
            end
        end else if (REDUCTION_TYPE == 2) begin : g_montgomery
            localparam logic [WIDTH-1:0] QINV = neg_qinv();
            logic [WIDTH-1:0] m;
            logic [PW:0]      sum;
            logic [WIDTH:0]   t;
            // REDC with R = 2^WIDTH; result carries the R^-1 factor.
            always_comb begin
                m   = WIDTH'(prod) * QINV;
                sum = (PW+1)'(prod) + (PW+1)'(PW'(m) * QP);
                t   = (WIDTH+1)'(sum >> WIDTH);
                p   = (t >= (WIDTH+1)'(Q)) ? WIDTH'(t - (WIDTH+1)'(Q)) : WIDTH'(t);
            end
        end else begin : g_simple
            assign p = WIDTH'(prod % QP);
        end
    endgenerate
endmodule

module ntt_butterfly_pipe #(
    parameter int WIDTH          = 32,
    parameter int Q              = 3329,
    parameter int REDUCTION_TYPE = 0,
    parameter int TAG_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_w,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [TAG_W-1:0] out_tag,
    output logic             err
);
    localparam logic [WIDTH-1:0] QW = WIDTH'(Q);
    localparam logic [WIDTH:0]   QE = (WIDTH+1)'(Q);

    function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [WIDTH:0] r;
        r = {1'b0, x} + {1'b0, y};
        if (r >= QE) begin
            r = r - QE;
        end
        return r[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [WIDTH:0] r;
        if (x >= y) begin
            r = {1'b0, x} - {1'b0, y};
        end else begin
            r = {1'b0, x} + QE - {1'b0, y};
        end
        return r[WIDTH-1:0];
    endfunction

    logic adv;
    logic in_fire;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign in_fire  = in_valid && in_ready;

    // Stage 1: registered inputs
    logic             s1_vld;
    logic             s1_mode;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [WIDTH-1:0] s1_w;
    logic [TAG_W-1:0] s1_tag;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
        end else if (adv) begin
            s1_vld <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            s1_mode <= in_mode;
            s1_a    <= in_a;
            s1_b    <= in_b;
            s1_w    <= in_w;
            s1_tag  <= in_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (in_fire && ((in_a >= QW) || (in_b >= QW) || (in_w >= QW))) begin
            err <= 1'b1;
        end
    end

    // Stage 2: the single multiplier serves both modes here. CT multiplies b*w;
    // GS folds its subtraction in front so (a-b)*w is ready one stage early.
    logic [WIDTH-1:0] gs_sum;
    logic [WIDTH-1:0] gs_diff;
    logic [WIDTH-1:0] mm_x;
    logic [WIDTH-1:0] mm_p;

    always_comb begin
        gs_sum  = mod_add(s1_a, s1_b);
        gs_diff = mod_sub(s1_a, s1_b);
        mm_x    = s1_mode ? gs_diff : s1_b;
    end

    mod_mult #(
        .WIDTH          (WIDTH),
        .Q              (Q),
        .REDUCTION_TYPE (REDUCTION_TYPE)
    ) u_mod_mult (
        .x (mm_x),
        .y (s1_w),
        .p (mm_p)
    );

    logic             s2_vld;
    logic             s2_mode;
    logic [WIDTH-1:0] s2_x;
    logic [WIDTH-1:0] s2_y;
    logic [TAG_W-1:0] s2_tag;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_vld <= 1'b0;
        end else if (adv) begin
            s2_vld <= s1_vld;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            s2_mode <= s1_mode;
            s2_x    <= s1_mode ? gs_sum : s1_a;
            s2_y    <= mm_p;
            s2_tag  <= s1_tag;
        end
    end

    // Stage 3: CT finishes with a +/- t; GS results are already complete.
    logic [WIDTH-1:0] res_a;
    logic [WIDTH-1:0] res_b;

    always_comb begin
        res_a = s2_x;
        res_b = s2_y;
        if (!s2_mode) begin
            res_a = mod_add(s2_x, s2_y);
            res_b = mod_sub(s2_x, s2_y);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_tag   <= '0;
        end else if (adv) begin
            out_valid <= s2_vld;
            out_a     <= res_a;
            out_b     <= res_b;
            out_tag   <= s2_tag;
        end
    end
endmodule

// File: tb/tb_ntt_butterfly_pipe.sv
// Randomized and directed checks of ntt_butterfly_pipe against a plain-arithmetic reference.
module tb_ntt_butterfly_pipe;
    localparam int WIDTH = 32;
    localparam int Q     = 3329;
    localparam int TAG_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic             in_mode;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_w;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic [TAG_W-1:0] out_tag;
    logic             err;

    ntt_butterfly_pipe #(.WIDTH(WIDTH), .Q(Q), .REDUCTION_TYPE(0), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_a(in_a), .in_b(in_b), .in_w(in_w), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_a(out_a), .out_b(out_b), .out_tag(out_tag), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        longint a;
        longint b;
        int     tag;
        bit     chk;
    } exp_t;

    exp_t model_q[$];

    logic             in_fire;
    logic             got_out;
    logic [WIDTH-1:0] cap_a;
    logic [WIDTH-1:0] cap_b;
    logic [TAG_W-1:0] cap_tag;

    function automatic exp_t ref_model(longint a, longint b, longint w, bit mode, int tag);
        exp_t e;
        longint t;
        if (!mode) begin
            t   = (b * w) % Q;
            e.a = (a + t) % Q;
            e.b = (a - t + Q) % Q;
        end else begin
            e.a = (a + b) % Q;
            e.b = (((a - b + Q) % Q) * w) % Q;
        end
        e.tag = tag;
        e.chk = (a < Q) && (b < Q) && (w < Q);
        return e;
    endfunction

    function automatic bit pop_exp(output exp_t e);
        e = '{0, 0, 0, 1'b0};
        if (model_q.size() == 0) return 1'b0;
        e = model_q.pop_front();
        return 1'b1;
    endfunction

    // One clock: sample handshakes mid-cycle, let the edge happen, return 1ns after it.
    task automatic step();
        @(negedge clk);
        in_fire = !rst && in_valid && in_ready;
        got_out = !rst && out_valid && out_ready;
        cap_a   = out_a;
        cap_b   = out_b;
        cap_tag = out_tag;
        if (in_fire) model_q.push_back(ref_model(longint'(in_a), longint'(in_b), longint'(in_w), in_mode, int'(in_tag)));
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] w,
                         input logic mode, input logic [TAG_W-1:0] tag);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_w     = w;
        in_mode  = mode;
        in_tag   = tag;
    endtask

    task automatic drive_rand(input logic [TAG_W-1:0] tag);
        drive($urandom_range(Q - 1), $urandom_range(Q - 1), $urandom_range(Q - 1), 1'($urandom_range(1)), tag);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if ({out_valid, err, out_a, out_b, out_tag} !== '0) begin
            errors++;
            $display("FAIL reset_state: valid=%0b err=%0b a=%0d b=%0d tag=%0d, required all 0",
                     out_valid, err, out_a, out_b, out_tag);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %0b required 1", in_ready);
        end
    endtask

    task automatic test_vectors();
        int va[4] = '{5, 5, 3328, 0};
        int vb[4] = '{7, 7, 1, 0};
        int vw[4] = '{3, 3, 1, 1234};
        int vm[4] = '{0, 1, 0, 0};
        int ea[4] = '{26, 12, 0, 0};
        int eb[4] = '{3313, 3323, 3327, 0};
        exp_t e;
        int n;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(WIDTH'(va[i]), WIDTH'(vb[i]), WIDTH'(vw[i]), vm[i][0], TAG_W'(8'hA0 + i));
            step();
            in_valid = 1'b0;
            checks++;
            if (!in_fire) begin
                errors++;
                $display("FAIL vec%0d_accept: in_ready=%0b required 1", i, in_ready);
            end
            n = 0;
            do begin
                step();
                n++;
            end while (!got_out && n < 10);
            checks++;
            if (n != 3) begin
                errors++;
                $display("FAIL vec%0d_latency: consumed %0d edges after accept, required 3", i, n);
            end
            void'(pop_exp(e));
            checks++;
            if (cap_a !== WIDTH'(ea[i]) || cap_b !== WIDTH'(eb[i]) || cap_tag !== TAG_W'(8'hA0 + i)) begin
                errors++;
                $display("FAIL vec%0d_data: got a=%0d b=%0d tag=%0h required a=%0d b=%0d tag=%0h",
                         i, cap_a, cap_b, cap_tag, ea[i], eb[i], 8'hA0 + i);
            end
        end
    endtask

    task automatic test_backpressure();
        int idx = 1;
        int acc = 0;
        int rcv = 0;
        int n = 0;
        logic [WIDTH-1:0] hold_a;
        logic [WIDTH-1:0] hold_b;
        exp_t e;
        out_ready = 1'b0;
        drive_rand(TAG_W'(idx));
        for (int c = 0; c < 5; c++) begin
            step();
            if (in_fire) begin
                acc++;
                idx++;
                if (idx <= 4) drive_rand(TAG_W'(idx));
                else in_valid = 1'b0;
            end
            if (c == 3) begin
                hold_a = cap_a;
                hold_b = cap_b;
            end
        end
        checks++;
        if (acc != 3 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_fill: accepted %0d in_ready=%0b required 3 and 0", acc, in_ready);
        end
        checks++;
        if (out_valid !== 1'b1 || cap_tag !== TAG_W'(1) || cap_a !== hold_a || cap_b !== hold_b) begin
            errors++;
            $display("FAIL bp_stable: valid=%0b tag=%0d a=%0d/%0d b=%0d/%0d required stable tag 1",
                     out_valid, cap_tag, cap_a, hold_a, cap_b, hold_b);
        end
        out_ready = 1'b1;
        while ((rcv < 4) && (n < 30)) begin
            step();
            n++;
            if (in_fire) begin
                idx++;
                if (idx <= 4) drive_rand(TAG_W'(idx));
                else in_valid = 1'b0;
            end
            if (got_out) begin
                rcv++;
                checks++;
                if (!pop_exp(e) || cap_tag !== TAG_W'(rcv) || cap_a !== WIDTH'(e.a) || cap_b !== WIDTH'(e.b)) begin
                    errors++;
                    $display("FAIL bp_order: got tag=%0d a=%0d b=%0d required tag=%0d a=%0d b=%0d",
                             cap_tag, cap_a, cap_b, rcv, e.a, e.b);
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (rcv != 4 || model_q.size() != 0) begin
            errors++;
            $display("FAIL bp_count: received %0d pending %0d required 4 and 0", rcv, model_q.size());
        end
    endtask

    task automatic test_throughput();
        int sent = 0;
        int rcv = 0;
        int n = 0;
        int stalls = 0;
        int gaps = 0;
        exp_t e;
        out_ready = 1'b1;
        drive_rand(TAG_W'(0));
        while ((rcv < 100) && (n < 300)) begin
            step();
            n++;
            if (in_valid) begin
                if (in_fire) begin
                    sent++;
                    if (sent < 100) drive_rand(TAG_W'(sent));
                    else in_valid = 1'b0;
                end else begin
                    stalls++;
                end
            end
            if (got_out) begin
                checks++;
                if (!pop_exp(e) || cap_a !== WIDTH'(e.a) || cap_b !== WIDTH'(e.b) || cap_tag !== TAG_W'(rcv)) begin
                    errors++;
                    $display("FAIL thru_data%0d: got a=%0d b=%0d tag=%0d required a=%0d b=%0d tag=%0d",
                             rcv, cap_a, cap_b, cap_tag, e.a, e.b, rcv & 8'hFF);
                end
                rcv++;
            end else if (rcv > 0) begin
                gaps++;
            end
        end
        checks++;
        if (rcv != 100 || stalls != 0 || gaps != 0) begin
            errors++;
            $display("FAIL thru_rate: received %0d stalls %0d gaps %0d required 100 0 0", rcv, stalls, gaps);
        end
    endtask

    task automatic test_reset_inflight();
        int stale = 0;
        out_ready = 1'b1;
        drive(WIDTH'(Q), WIDTH'(1), WIDTH'(1), 1'b0, TAG_W'(8'h55));
        step();
        drive_rand(TAG_W'(8'h56));
        step();
        in_valid = 1'b0;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL rst_err_before: err=%0b required 1", err);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_q.delete();
        checks++;
        if (out_valid !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL rst_inflight: valid=%0b err=%0b required 0 0", out_valid, err);
        end
        for (int c = 0; c < 6; c++) begin
            step();
            if (got_out) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL rst_stale: %0d results after reset, required 0", stale);
        end
    endtask

    task automatic test_err();
        int rcv = 0;
        int n = 0;
        int sent = 0;
        exp_t e;
        out_ready = 1'b1;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: err=%0b required 0", err);
        end
        drive(WIDTH'(3329), WIDTH'(2), WIDTH'(3), 1'b0, TAG_W'(0));
        while ((rcv < 4) && (n < 40)) begin
            step();
            n++;
            if (in_fire) begin
                if (sent == 0) begin
                    checks++;
                    if (err !== 1'b1) begin
                        errors++;
                        $display("FAIL err_set: err=%0b required 1", err);
                    end
                end
                sent++;
                if (sent < 4) drive_rand(TAG_W'(sent));
                else in_valid = 1'b0;
            end
            if (got_out) begin
                checks++;
                if (!pop_exp(e) || cap_tag !== TAG_W'(rcv) || (e.chk && (cap_a !== WIDTH'(e.a) || cap_b !== WIDTH'(e.b)))) begin
                    errors++;
                    $display("FAIL err_flow%0d: got a=%0d b=%0d tag=%0d required a=%0d b=%0d tag=%0d",
                             rcv, cap_a, cap_b, cap_tag, e.a, e.b, rcv);
                end
                rcv++;
            end
        end
        for (int c = 0; c < 8; c++) step();
        checks++;
        if (err !== 1'b1 || rcv != 4) begin
            errors++;
            $display("FAIL err_sticky: err=%0b received %0d required 1 and 4", err, rcv);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_reset: err=%0b required 0", err);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_w      = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        test_reset();
        test_vectors();
        test_backpressure();
        test_throughput();
        test_reset_inflight();
        test_err();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
